// File: rtl/tdpr_pkg.sv
// Shared types for the dual-port RAM copy/fill engine.
package tdpr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    MODE_COPY = 1'b0,
    MODE_FILL = 1'b1
  } mode_e;

endpackage

// File: rtl/tdpr_addr_gen.sv
// Loadable up/down word-address counter with a remaining-count register.
// last is high while the final address of the block is presented.
module tdpr_addr_gen #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic                  down,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] ONE_A = 1;
  localparam logic [ADDR_WIDTH:0]   ONE_L = 1;

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic                  down_q, down_d;

  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    down_d = down_q;
    if (load) begin
      down_d = down;
      rem_d  = len;
      // Range is checked before load, so modulo arithmetic gives base+len-1 exactly.
      addr_d = down ? (base + len[ADDR_WIDTH-1:0] - ONE_A) : base;
    end else if (step) begin
      addr_d = down_q ? (addr_q - ONE_A) : (addr_q + ONE_A);
      rem_d  = rem_q - ONE_L;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      rem_q  <= '0;
      down_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      down_q <= down_d;
    end
  end

  assign addr = addr_q;
  assign last = (rem_q == ONE_L);

endmodule

// File: rtl/tdpr_copy_engine.sv
// Block copy/fill initiator for a true dual-port RAM: reads on port A,
// writes on port B, one word per clock.
module tdpr_copy_engine
  import tdpr_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode_fill,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [DATA_WIDTH-1:0] pattern,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  aborted,
  output logic [ADDR_WIDTH:0]   words_done,
  output logic                  en_a,
  output logic                  we_a,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [DATA_WIDTH-1:0] data_in_a,
  input  logic [DATA_WIDTH-1:0] data_out_a,
  output logic                  en_b,
  output logic                  we_b,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] data_in_b,
  input  logic [DATA_WIDTH-1:0] data_out_b
);

  localparam logic [ADDR_WIDTH+1:0] DEPTH_X = (ADDR_WIDTH+2)'(RAM_DEPTH);

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic                  en_a_q, en_a_d;
  logic                  en_b_q, en_b_d;
  logic                  err_q, err_d;
  logic                  aborted_q, aborted_d;
  logic [ADDR_WIDTH:0]   words_done_q, words_done_d;
  logic [DATA_WIDTH-1:0] pattern_q, pattern_d;

  logic [ADDR_WIDTH+1:0] dst_end, src_end;
  logic                  range_err, desc, gen_load, is_copy, run_last, stop;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
  logic                  rd_last, wr_last;
  logic                  unused_data_out_b;

  assign unused_data_out_b = ^data_out_b;

  assign dst_end   = {2'b00, dst_addr} + {1'b0, length};
  assign src_end   = {2'b00, src_addr} + {1'b0, length};
  assign range_err = (dst_end > DEPTH_X) || (!mode_fill && (src_end > DEPTH_X));
  // Copying high-to-low keeps overlapping moves with dst above src correct.
  assign desc      = !mode_fill && (dst_addr > src_addr);

  assign is_copy  = (mode_q == MODE_COPY);
  assign run_last = is_copy ? rd_last : wr_last;
  assign stop     = abort || run_last;

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    en_a_d       = 1'b0;
    en_b_d       = 1'b0;
    err_d        = err_q;
    aborted_d    = aborted_q;
    words_done_d = words_done_q + {{ADDR_WIDTH{1'b0}}, en_b_q};
    pattern_d    = pattern_q;
    gen_load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d        = 1'b0;
          aborted_d    = 1'b0;
          words_done_d = '0;
          mode_d       = mode_fill ? MODE_FILL : MODE_COPY;
          pattern_d    = pattern;
          if (range_err) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if (length == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_RUN;
            gen_load = 1'b1;
            en_a_d   = !mode_fill;
            en_b_d   = mode_fill;
          end
        end
      end
      ST_RUN: begin
        // Copy writes trail reads by one cycle; the final read is written in DRAIN.
        en_a_d = is_copy && !stop;
        en_b_d = is_copy ? en_a_q : !stop;
        if (abort) aborted_d = 1'b1;
        if (stop) state_d = is_copy ? ST_DRAIN : ST_DONE;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_COPY;
      en_a_q       <= 1'b0;
      en_b_q       <= 1'b0;
      err_q        <= 1'b0;
      aborted_q    <= 1'b0;
      words_done_q <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      en_a_q       <= en_a_d;
      en_b_q       <= en_b_d;
      err_q        <= err_d;
      aborted_q    <= aborted_d;
      words_done_q <= words_done_d;
    end
  end

  always_ff @(posedge clk) begin
    pattern_q <= pattern_d;
  end

  tdpr_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_gen (
    .clk  (clk),
    .rst  (rst),
    .load (gen_load),
    .step (en_a_q),
    .down (desc),
    .base (src_addr),
    .len  (length),
    .addr (rd_addr),
    .last (rd_last)
  );

  tdpr_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_gen (
    .clk  (clk),
    .rst  (rst),
    .load (gen_load),
    .step (en_b_q),
    .down (desc),
    .base (dst_addr),
    .len  (length),
    .addr (wr_addr),
    .last (wr_last)
  );

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;
  assign aborted    = aborted_q;
  assign words_done = words_done_q;
  assign en_a       = en_a_q;
  assign we_a       = 1'b0;
  assign addr_a     = rd_addr;
  assign data_in_a  = '0;
  assign en_b       = en_b_q;
  assign we_b       = en_b_q;
  assign addr_b     = wr_addr;
  assign data_in_b  = en_b_q ? (is_copy ? data_out_a : pattern_q) : '0;

endmodule

// File: tb/tb_tdpr_copy_engine.sv
// Directed bench for tdpr_copy_engine with a behavioural RAM and a job-level
// timing/content model checked every cycle of each job.
module tb_tdpr_copy_engine;

  logic       clk = 1'b0;
  logic       rst, start, mode_fill, abort;
  logic [7:0] src_addr, dst_addr, pattern;
  logic [8:0] length;
  logic       busy, done, err, aborted;
  logic [8:0] words_done;
  logic       en_a, we_a, en_b, we_b;
  logic [7:0] addr_a, data_in_a, data_out_a, addr_b, data_in_b, data_out_b;

  always #5 clk = ~clk;

  tdpr_copy_engine #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_fill(mode_fill),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .pattern(pattern),
    .abort(abort), .busy(busy), .done(done), .err(err), .aborted(aborted),
    .words_done(words_done), .en_a(en_a), .we_a(we_a), .addr_a(addr_a),
    .data_in_a(data_in_a), .data_out_a(data_out_a), .en_b(en_b), .we_b(we_b),
    .addr_b(addr_b), .data_in_b(data_in_b), .data_out_b(data_out_b)
  );

  // RAM: 256 x 8, 1-clock read latency on port A, write on port B.
  logic [7:0] mem [256];
  logic [7:0] rd_a;
  logic       pl_en;
  logic [7:0] pl_addr, pl_data;
  always @(posedge clk) begin
    if (en_a && !we_a) rd_a <= mem[addr_a];
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (en_b && we_b) mem[addr_b] <= data_in_b;
  end
  assign data_out_a = rd_a;
  assign data_out_b = 8'h00;

  int checks = 0;
  int errors = 0;

  logic       j_active = 1'b0, j_fin = 1'b0;
  int         j_t, j_len, j_abort_at, run_c, done_t;
  logic       j_fill, j_desc, j_err;
  logic [7:0] j_src, j_dst, j_pat;
  logic [7:0] snap [256];
  logic [7:0] exp_mem [256];
  int         seen_done_t, first_a, enb_cnt;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] a_rd(input int i);
    return j_desc ? 8'(int'(j_src) + j_len - 1 - i) : 8'(int'(j_src) + i);
  endfunction

  function automatic logic [7:0] a_wr(input int i);
    return j_desc ? 8'(int'(j_dst) + j_len - 1 - i) : 8'(int'(j_dst) + i);
  endfunction

  function automatic logic [7:0] wdat(input int i);
    return j_fill ? j_pat : snap[a_rd(i)];
  endfunction

  function automatic int clampw(input int v);
    if (v < 0) return 0;
    if (v > run_c) return run_c;
    return v;
  endfunction

  task automatic check_zero(input string nm);
    chk({nm, "_ctrl"}, int'({busy, done, err, aborted, words_done, en_a, we_a, en_b, we_b}), 0);
    chk({nm, "_bus"}, int'({addr_a, data_in_a, addr_b, data_in_b}), 0);
  endtask

  // Per-cycle compare: t counts cycles after the start edge.
  initial forever begin
    int  t, wi;
    logic ea, eb;
    @(posedge clk);
    #1;
    if (j_active) begin
      j_t++;
      t  = j_t;
      ea = !j_fill && t >= 1 && t <= run_c;
      eb = j_fill ? (t >= 1 && t <= run_c) : (t >= 2 && t <= run_c + 1);
      wi = j_fill ? t - 1 : t - 2;
      chk("busy", busy, int'(t <= done_t));
      chk("done", done, int'(t == done_t));
      chk("en_a", en_a, ea);
      chk("we_a", we_a, 0);
      chk("data_in_a", data_in_a, 0);
      chk("en_b", en_b, eb);
      chk("we_b", we_b, eb);
      if (ea) chk("addr_a", addr_a, a_rd(t - 1));
      if (eb) begin
        chk("addr_b", addr_b, a_wr(wi));
        chk("data_in_b", data_in_b, wdat(wi));
      end
      chk("words_done", words_done, clampw(wi));
      chk("err", err, j_err);
      chk("aborted", aborted, int'(j_abort_at != 0 && t > j_abort_at));
      if (done && seen_done_t < 0) seen_done_t = t;
      if (en_a && first_a < 0) first_a = addr_a;
      if (en_b) enb_cnt++;
      if (t > done_t) begin
        j_active = 1'b0;
        j_fin    = 1'b1;
      end
    end
  end

  task automatic run_job(input string nm, input logic fill, input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] p, input int len, input int abort_at, input int rst_at,
                         input int stray_at);
    int n, bad;
    logic did_rst;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      snap[i]    = mem[i];
      exp_mem[i] = mem[i];
    end
    j_fill = fill; j_src = s; j_dst = d; j_pat = p; j_len = len; j_abort_at = abort_at;
    j_desc = !fill && (d > s);
    j_err  = (int'(d) + len > 256) || (!fill && (int'(s) + len > 256));
    if (j_err || len == 0) begin
      run_c = 0; done_t = 1;
    end else begin
      run_c  = (abort_at > 0) ? abort_at : len;
      done_t = run_c + (fill ? 1 : 2);
    end
    seen_done_t = -1; first_a = -1; enb_cnt = 0; j_t = 0; j_fin = 1'b0; j_active = 1'b1;
    mode_fill = fill; src_addr = s; dst_addr = d; pattern = p; length = 9'(len); start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    did_rst = 1'b0;
    for (int c = 0; c < 1000 && !j_fin; c++) begin
      abort = (abort_at > 0 && j_t == abort_at);
      if (stray_at > 0 && j_t == stray_at) begin
        start = 1'b1; mode_fill = !fill; dst_addr = 8'h00; src_addr = 8'h00; length = 9'd5;
      end else begin
        start = 1'b0;
      end
      if (rst_at > 0 && j_t == rst_at) begin
        rst = 1'b1; j_active = 1'b0; did_rst = 1'b1;
        break;
      end
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b0;
    if (did_rst) begin
      @(posedge clk);
      #1;
      check_zero({nm, "_midrst"});
      @(negedge clk);
      rst = 1'b0;
      n   = clampw(fill ? rst_at : rst_at - 1);
    end else begin
      if (!j_fin) chk({nm, "_timeout"}, 0, 1);
      j_active = 1'b0;
      n = run_c;
    end
    for (int i = 0; i < n; i++) exp_mem[a_wr(i)] = wdat(i);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
    chk({nm, "_ram"}, bad, 0);
  endtask

  initial begin
    int bad;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mode_fill = 1'b0;
    src_addr = 8'h00; dst_addr = 8'h00; pattern = 8'h00; length = 9'd0;
    pl_en = 1'b0; pl_addr = 8'h00; pl_data = 8'h00;
    repeat (3) @(negedge clk);
    check_zero("reset");
    for (int i = 0; i < 256; i++) begin
      pl_en = 1'b1; pl_addr = 8'(i); pl_data = (i < 8) ? 8'(i) : 8'h00;
      @(negedge clk);
    end
    pl_en = 1'b0;
    rst   = 1'b0;
    @(negedge clk);

    run_job("fill", 1'b1, 8'h00, 8'h10, 8'hA5, 4, 0, 0, 0);
    for (int i = 0; i < 4; i++) chk("t1_ram_a5", mem[8'h10 + i], 8'hA5);
    chk("t1_done_lat", seen_done_t, 5);
    chk("t1_words", words_done, 4);

    run_job("copy", 1'b0, 8'h00, 8'h40, 8'h00, 8, 0, 0, 3);
    bad = 0;
    for (int i = 0; i < 8; i++) if (mem[8'h40 + i] !== 8'(i)) bad++;
    chk("t2_ram_lit", bad, 0);
    chk("t2_done_lat", seen_done_t, 10);

    run_job("overlap", 1'b0, 8'h00, 8'h02, 8'h00, 8, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < 8; i++) if (mem[2 + i] !== 8'(i)) bad++;
    chk("t3_ram_lit", bad, 0);
    chk("t3_first_addr_a", first_a, 7);

    run_job("err_dst", 1'b0, 8'h00, 8'hFE, 8'h00, 4, 0, 0, 0);
    chk("t4_err", err, 1);
    chk("t4_done_lat", seen_done_t, 1);
    chk("t4_enb_cnt", enb_cnt, 0);
    run_job("err_src", 1'b0, 8'hFC, 8'h20, 8'h00, 8, 0, 0, 0);
    chk("t4_src_err", err, 1);
    run_job("len0", 1'b1, 8'h00, 8'h30, 8'h11, 0, 0, 0, 0);
    chk("t4_len0_err", err, 0);
    chk("t4_len0_done_lat", seen_done_t, 1);

    run_job("abort_fill", 1'b1, 8'h00, 8'h90, 8'h3C, 100, 10, 0, 0);
    chk("t5_words", words_done, 10);
    chk("t5_aborted", aborted, 1);
    chk("t5_enb_cnt", enb_cnt, 10);
    chk("t5_done_lat", seen_done_t, 11);
    run_job("abort_copy", 1'b0, 8'h00, 8'h60, 8'h00, 8, 3, 0, 0);
    chk("t5c_words", words_done, 3);
    chk("t5c_done_lat", seen_done_t, 5);

    run_job("rst_mid", 1'b0, 8'h40, 8'h80, 8'h00, 8, 0, 4, 0);
    chk("t6_ram_87", mem[8'h87], 8'h07);
    chk("t6_ram_84", mem[8'h84], 8'h00);
    run_job("after_rst", 1'b1, 8'h00, 8'hC0, 8'h5A, 3, 0, 0, 0);
    chk("t6_done_lat", seen_done_t, 4);
    chk("t6_ram_c2", mem[8'hC2], 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
